// File: rtl/herzel_tone_gen.sv
// ----------------------------------------------------------------------------
// herzel_tone_gen
//  Multi-tone test-signal synthesizer. NF recursive oscillators
//  y[n] = alpha*y[n-1] - y[n-2] (alpha = 2cos(w)) are summed into one signed
//  32.32 sample stream that is handed downstream through valid/ready.
//  A single 64x64 multiplier is shared by all tones, one tone per cycle, so a
//  sample costs NF accumulate cycles plus at least one output cycle.
//
// Ports
//  clk      clock, everything on posedge
//  rst      synchronous reset, active-high; aborts a burst silently
//  start    begin a burst (only looked at in IDLE)
//  ns_i     samples per burst
//  alpha_i  per-tone 2cos(w), packed, tone k at [k*DW +: DW], signed 32.32
//  init_i   per-tone A*sin(w), packed like alpha_i, signed 32.32
//  mask_i   per-tone enable into the output sum
//  ready_i  downstream accepts data_o this cycle
//  valid_o  data_o holds a sample
//  data_o   saturated sum of the enabled tones, signed 32.32
//  busy_o   burst in progress
//  done_o   one-cycle pulse at burst end
// ----------------------------------------------------------------------------
module herzel_tone_gen #(
    parameter int NF = 3,
    parameter int DW = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      ns_i,
    input  logic [NF*DW-1:0] alpha_i,
    input  logic [NF*DW-1:0] init_i,
    input  logic [NF-1:0]    mask_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [DW-1:0]    data_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int KW = (NF > 1) ? $clog2(NF) : 1;
    // Headroom for summing NF full-scale tones before saturation.
    localparam int AW = DW + $clog2(NF) + 1;
    // Fraction bits of the 32.32 format.
    localparam int FW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                r_state;
    logic [31:0]           r_ns;
    logic [31:0]           r_cnt;
    logic [NF-1:0]         r_mask;
    logic signed [DW-1:0]  r_alpha [NF];
    logic signed [DW-1:0]  r_cur   [NF];
    logic signed [DW-1:0]  r_prv   [NF];
    logic [KW-1:0]         r_k;
    logic signed [AW-1:0]  r_acc;
    logic                  r_valid;
    logic                  r_done;
    logic [DW-1:0]         r_data;

    // Unpacked views of the packed per-tone inputs.
    logic signed [DW-1:0]  w_alpha_in [NF];
    logic signed [DW-1:0]  w_init_in  [NF];

    for (genvar gi = 0; gi < NF; gi++) begin : g_unpack
        assign w_alpha_in[gi] = alpha_i[gi*DW +: DW];
        assign w_init_in[gi]  = init_i[gi*DW +: DW];
    end

    // Datapath for the tone selected by r_k.
    logic signed [DW-1:0]   w_alpha_k;
    logic signed [DW-1:0]   w_cur_k;
    logic signed [DW-1:0]   w_prv_k;
    logic                   w_mask_k;
    logic signed [2*DW-1:0] w_alpha_x;
    logic signed [2*DW-1:0] w_cur_x;
    logic signed [2*DW-1:0] w_prod;
    logic signed [DW-1:0]   w_mulq;
    logic signed [DW-1:0]   w_nxt;
    logic signed [AW-1:0]   w_term;
    logic signed [AW-1:0]   w_sum;
    logic                   w_in_range;
    logic [DW-1:0]          w_sat;

    assign w_alpha_k = r_alpha[r_k];
    assign w_cur_k   = r_cur[r_k];
    assign w_prv_k   = r_prv[r_k];
    assign w_mask_k  = r_mask[r_k];

    // Operands are sign-extended to the full product width so the low 2*DW
    // bits of the product are the exact signed result.
    assign w_alpha_x = {{DW{w_alpha_k[DW-1]}}, w_alpha_k};
    assign w_cur_x   = {{DW{w_cur_k[DW-1]}}, w_cur_k};
    assign w_prod    = w_alpha_x * w_cur_x;
    // Arithmetic shift then truncate: bits [DW+FW-1:FW], rounding toward -inf.
    assign w_mulq    = DW'(w_prod >>> FW);
    // Oscillator update wraps modulo 2^DW.
    assign w_nxt     = w_mulq - w_prv_k;

    assign w_term = w_mask_k ? {{(AW-DW){w_cur_k[DW-1]}}, w_cur_k} : '0;
    assign w_sum  = r_acc + w_term;

    // The sum fits in DW bits when all bits from DW-1 upward agree.
    assign w_in_range = (&w_sum[AW-1:DW-1]) | ~(|w_sum[AW-1:DW-1]);
    assign w_sat = w_in_range  ? w_sum[DW-1:0] :
                   w_sum[AW-1] ? {1'b1, {(DW-1){1'b0}}} :
                                 {1'b0, {(DW-1){1'b1}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ns    <= '0;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
            for (int k = 0; k < NF; k++) begin
                r_alpha[k] <= '0;
                r_cur[k]   <= '0;
                r_prv[k]   <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ns   <= ns_i;
                        r_mask <= mask_i;
                        r_cnt  <= '0;
                        r_k    <= '0;
                        r_acc  <= '0;
                        // y[0]=0 and y[-1]=-A*sin(w) make y[1]=A*sin(w).
                        for (int k = 0; k < NF; k++) begin
                            r_alpha[k] <= w_alpha_in[k];
                            r_cur[k]   <= '0;
                            r_prv[k]   <= -w_init_in[k];
                        end
                        if (ns_i == 32'd0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ACC;
                        end
                    end
                end

                ACC: begin
                    r_acc      <= w_sum;
                    r_prv[r_k] <= w_cur_k;
                    r_cur[r_k] <= w_nxt;
                    if (r_k == KW'(NF-1)) begin
                        r_data  <= w_sat;
                        r_valid <= 1'b1;
                        r_state <= OUT;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end

                OUT: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_cnt   <= r_cnt + 32'd1;
                        if (r_cnt == r_ns - 32'd1) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_acc   <= '0;
                            r_k     <= '0;
                            r_state <= ACC;
                        end
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign done_o  = r_done;
    assign busy_o  = (r_state != IDLE);

endmodule

// File: tb/tb_herzel_tone_gen.sv
// ----------------------------------------------------------------------------
// tb_herzel_tone_gen
//  Scoreboard bench: each burst's expected samples are generated by a
//  behavioural oscillator model and queued when the burst is started, then
//  popped and compared as the DUT hands samples over. Latency, stall
//  stability, done pulses, reset abort and start-while-busy are also checked.
// ----------------------------------------------------------------------------
module tb_herzel_tone_gen;

    localparam int NF  = 3;
    localparam int DW  = 64;
    localparam int LAT = NF + 1;

    localparam logic signed [66:0] SMAX = 67'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [66:0] SMIN = -67'sh0_8000_0000_0000_0000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      ns_i;
    logic [NF*DW-1:0] alpha_i;
    logic [NF*DW-1:0] init_i;
    logic [NF-1:0]    mask_i;
    logic             ready_i;
    logic             valid_o;
    logic [DW-1:0]    data_o;
    logic             busy_o;
    logic             done_o;

    herzel_tone_gen #(.NF(NF), .DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ns_i    (ns_i),
        .alpha_i (alpha_i),
        .init_i  (init_i),
        .mask_i  (mask_i),
        .ready_i (ready_i),
        .valid_o (valid_o),
        .data_o  (data_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
        end
    endtask

    // Reference oscillator bank: pushes the expected sample stream of a burst.
    task automatic model_push(input int ns, input logic [NF*DW-1:0] a,
                              input logic [NF*DW-1:0] ini, input logic [NF-1:0] m);
        logic signed [63:0]  cur [NF];
        logic signed [63:0]  prv [NF];
        logic signed [63:0]  ak;
        logic signed [63:0]  nxt;
        logic signed [127:0] p;
        logic signed [66:0]  acc;
        for (int k = 0; k < NF; k++) begin
            cur[k] = '0;
            prv[k] = -$signed(ini[k*64 +: 64]);
        end
        for (int s = 0; s < ns; s++) begin
            acc = '0;
            for (int k = 0; k < NF; k++)
                if (m[k]) acc = acc + 67'(cur[k]);
            for (int k = 0; k < NF; k++) begin
                ak     = a[k*64 +: 64];
                p      = 128'(ak) * 128'(cur[k]);
                nxt    = p[95:32] - prv[k];
                prv[k] = cur[k];
                cur[k] = nxt;
            end
            if (acc > SMAX)      exp_q.push_back(64'h7FFF_FFFF_FFFF_FFFF);
            else if (acc < SMIN) exp_q.push_back(64'h8000_0000_0000_0000);
            else                 exp_q.push_back(acc[63:0]);
        end
    endtask

    // One burst. Inputs are scrambled right after start is taken; with
    // restart=1 a second start is presented while the burst is busy.
    // abort_idx >= 0 asserts rst in the ACC phase of that sample.
    task automatic run_burst(input string name, input int ns,
                             input logic [NF*DW-1:0] a, input logic [NF*DW-1:0] ini,
                             input logic [NF-1:0] m, input int stall_idx,
                             input int stall_len, input int abort_idx, input bit restart);
        int lat;
        int viol;
        logic [63:0] held;
        logic [63:0] exp;
        model_push(ns, a, ini, m);
        @(posedge clk); #1;
        start   = 1'b1;
        ns_i    = ns;
        alpha_i = a;
        init_i  = ini;
        mask_i  = m;
        ready_i = (stall_idx == 0) ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        start   = restart;
        ns_i    = 32'd2;
        alpha_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        init_i  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        mask_i  = ~m;

        if (ns == 0) begin
            @(negedge clk);
            chk({name, " ns0_done"}, 64'(done_o), 64'd1);
            chk({name, " ns0_valid"}, 64'(valid_o), 64'd0);
            @(posedge clk); #1;
            start = 1'b0;
            viol = 0;
            repeat (6) begin
                @(negedge clk);
                if (valid_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) viol++;
            end
            chk({name, " ns0_quiet"}, 64'(viol), 64'd0);
            $display("[%0t] %s burst ns=0 finished", $time, name);
            return;
        end

        for (int s = 0; s < ns; s++) begin
            if (s == abort_idx) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                chk({name, " abort_valid"}, 64'(valid_o), 64'd0);
                chk({name, " abort_data"}, data_o, 64'd0);
                chk({name, " abort_busy"}, 64'(busy_o), 64'd0);
                chk({name, " abort_done"}, 64'(done_o), 64'd0);
                exp_q.delete();
                viol = 0;
                repeat (8) begin
                    @(negedge clk);
                    if (valid_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) viol++;
                end
                chk({name, " abort_quiet"}, 64'(viol), 64'd0);
                $display("[%0t] %s aborted by reset at sample %0d", $time, name, s);
                return;
            end

            lat = 0;
            do begin
                @(negedge clk);
                lat++;
                if (s == 0 && lat == 1) chk({name, " busy"}, 64'(busy_o), 64'd1);
                if (lat == 2) start = 1'b0;
            end while (valid_o !== 1'b1 && lat < 20);
            chk({name, " latency"}, 64'(lat), 64'(LAT));
            if (valid_o !== 1'b1) return;

            held = data_o;
            if (s == stall_idx) begin
                viol = 0;
                repeat (stall_len) begin
                    @(negedge clk);
                    if (valid_o !== 1'b1 || data_o !== held) viol++;
                end
                chk({name, " stall_stable"}, 64'(viol), 64'd0);
                @(posedge clk); #1;
                ready_i = 1'b1;
                @(negedge clk);
            end

            if (exp_q.size() == 0) begin
                chk({name, " queue_underflow"}, 64'd1, 64'd0);
            end else begin
                exp = exp_q.pop_front();
                chk($sformatf("%s sample%0d", name, s), data_o, exp);
            end
            $display("[%0t] %s sample %0d data=0x%016h latency=%0d", $time, name, s, data_o, lat);
            @(posedge clk); #1;
            ready_i = (s + 1 == stall_idx) ? 1'b0 : 1'b1;
        end

        @(negedge clk);
        chk({name, " done_pulse"}, 64'(done_o), 64'd1);
        chk({name, " done_valid"}, 64'(valid_o), 64'd0);
        @(negedge clk);
        chk({name, " done_clear"}, 64'(done_o), 64'd0);
        chk({name, " idle_busy"}, 64'(busy_o), 64'd0);
    endtask

    localparam logic [63:0] ONE  = 64'h0000_0001_0000_0000;
    localparam logic [63:0] BIG  = 64'h7FFF_FFFF_0000_0000;

    initial begin
        rst = 1'b1; start = 1'b0; ns_i = '0; alpha_i = '0; init_i = '0;
        mask_i = '0; ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset valid", 64'(valid_o), 64'd0);
        chk("reset data", data_o, 64'd0);
        chk("reset busy", 64'(busy_o), 64'd0);
        chk("reset done", 64'(done_o), 64'd0);

        // alpha=0: 0, 1, 0, -1, 0
        run_burst("c1", 5, '0, {64'd0, 64'd0, ONE}, 3'b001, -1, 0, -1, 1'b0);
        // alpha=1.0: 0,1,1,0,-1,-1,0 back to back
        run_burst("c2", 7, {64'd0, 64'd0, ONE}, {64'd0, 64'd0, ONE}, 3'b001, -1, 0, -1, 1'b1);
        // stall on the third sample
        run_burst("c3", 5, '0, {64'd0, 64'd0, ONE}, 3'b001, 2, 10, -1, 1'b0);
        // three full-scale tones saturate both ways
        run_burst("c4", 4, '0, {BIG, BIG, BIG}, 3'b111, -1, 0, -1, 1'b0);
        // empty burst, second start while busy
        run_burst("c5", 0, '0, {64'd0, 64'd0, ONE}, 3'b001, -1, 0, -1, 1'b1);
        // reset in the middle, then clean replay
        run_burst("c6a", 5, '0, {64'd0, 64'd0, ONE}, 3'b001, -1, 0, 2, 1'b0);
        run_burst("c6b", 5, '0, {64'd0, 64'd0, ONE}, 3'b001, -1, 0, -1, 1'b0);
        // mixed tones with fractional and negative coefficients
        run_burst("c7", 10,
                  {64'h0000_0001_BB67_AE85, 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_6A09_E667},
                  {64'hFFFF_FFFF_4000_0000, 64'h0000_0002_0000_0000, 64'h0000_0000_8000_0000},
                  3'b101, 4, 3, -1, 1'b1);
        run_burst("c8", 6,
                  {64'h0000_0001_BB67_AE85, 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_6A09_E667},
                  {64'hFFFF_FFFF_4000_0000, 64'h0000_0002_0000_0000, 64'h0000_0000_8000_0000},
                  3'b111, -1, 0, -1, 1'b0);

        chk("queue_left", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
